vme_a16_regslave: RTL

Parametrised VME A16 slave with an internal register file. It decodes A16 short supervisory (AM 0x2D) and non-privileged (AM 0x29) cycles at a configurable base address. Supports D8(O) or D16 transfers with byte lanes, and answers with DTACK, or BERR for unimplemented registers. It sits between the VME transceivers and on-board logic, exporting registers and write strobes and importing read-only status words.

---
 rtl/vme_a16_regslave.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/vme_a16_regslave.sv
// vme_a16_regslave
//   VME A16 slave exposing a small register file. Decodes short supervisory
//   (AM 0x2D) and short non-privileged (AM 0x29) cycles at BASE. Supports D8(O)
//   and D16 byte-lane writes. Terminates implemented registers with DTACK and
//   unimplemented indices with BERR.
//
// Ports
//   CLK, CRST           clock, synchronous active-high reset
//   XA, XAM             VME address / address modifier (sampled at decode)
//   XAS, XDS, XWRITE    bus strobes and direction (double-synchronised)
//   XIACK               interrupt acknowledge, cycle ignored when low
//   XD_I / XD_O, XD_OE  data from / to the bus, read drive enable
//   DDIR                transceiver direction, 1 = board-to-bus
//   XDTACK(OE)          DTACK level and driver enable
//   XBERR(OE)           BERR level and driver enable
//   REGS                register contents, reg i at [i*DWIDTH +: DWIDTH]
//   STAT                read-only sources for registers flagged in RO_MASK
//   WSTB                one-cycle write strobe per register
//   BUSY                FSM not idle
module vme_a16_regslave #(
  parameter logic [14:0]      BASE     = 15'h179,
  parameter int               IDX_BITS = 3,
  parameter int               NREGS    = 8,
  parameter int               DWIDTH   = 16,
  parameter logic [NREGS-1:0] RO_MASK  = '0,
  parameter int               TMO      = 255
) (
  input  logic                    CLK,
  input  logic                    CRST,
  input  logic [15:0]             XA,
  input  logic [5:0]              XAM,
  input  logic                    XAS,
  input  logic [1:0]              XDS,
  input  logic                    XWRITE,
  input  logic                    XIACK,
  input  logic [DWIDTH-1:0]       XD_I,
  output logic [DWIDTH-1:0]       XD_O,
  output logic                    XD_OE,
  output logic                    DDIR,
  output logic                    XDTACK,
  output logic                    XDTACKOE,
  output logic                    XBERR,
  output logic                    XBERROE,
  output logic [NREGS*DWIDTH-1:0] REGS,
  input  logic [NREGS*DWIDTH-1:0] STAT,
  output logic [NREGS-1:0]        WSTB,
  output logic                    BUSY
);

  localparam int AW    = 15 - IDX_BITS;
  localparam int NIDX  = 2 ** IDX_BITS;
  localparam int LANES = DWIDTH / 8;
  localparam int CW    = $clog2(TMO + 2);
  localparam logic [AW-1:0]   BASE_CMP = BASE[AW-1:0];
  localparam logic [NIDX-1:0] RO_EXT   = NIDX'(RO_MASK);
  localparam logic [CW-1:0]   TMO_LAST = CW'((TMO == 0) ? 0 : TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_DRIVE, S_ACK, S_BERR, S_REL, S_WAITAS
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]          as_sync_reg, wr_sync_reg;
  logic [1:0]          ds_meta_reg, ds_sync_reg;
  logic [IDX_BITS-1:0] idx_reg;
  logic [CW-1:0]       cnt_reg;
  logic                rd_reg;
  logic [DWIDTH-1:0]   xd_o_reg;
  logic                xd_oe_reg, ddir_reg, busy_reg;
  logic                xdtack_reg, xdtackoe_reg, xberr_reg, xberroe_reg;
  logic [NREGS-1:0]    wstb_reg;

  logic              as_s, rd_s, ds_any, decode, idx_ok, is_ro, tmo_hit;
  logic [1:0]        lane_en;
  logic              wr_fire, rd_fire;
  logic [DWIDTH-1:0] rd_regs [NIDX];
  logic [DWIDTH-1:0] rd_stat [NIDX];
  logic [DWIDTH-1:0] rd_word;
  logic              unused_bits;

  assign unused_bits = XA[0];

  // Bus strobes are asynchronous to CLK; the FSM only ever sees these copies.
  always_ff @(posedge CLK) begin
    if (CRST) begin
      as_sync_reg <= 2'b11;
      wr_sync_reg <= 2'b11;
      ds_meta_reg <= 2'b11;
      ds_sync_reg <= 2'b11;
    end else begin
      as_sync_reg <= {as_sync_reg[0], XAS};
      wr_sync_reg <= {wr_sync_reg[0], XWRITE};
      ds_meta_reg <= XDS;
      ds_sync_reg <= ds_meta_reg;
    end
  end

  assign as_s       = as_sync_reg[1];
  assign rd_s       = wr_sync_reg[1];
  assign lane_en[0] = ~ds_sync_reg[0];
  assign lane_en[1] = (DWIDTH == 16) ? ~ds_sync_reg[1] : 1'b0;
  assign ds_any     = |lane_en;

  assign decode  = !as_s && (XAM == 6'h2D || XAM == 6'h29) && XIACK &&
                   (XA[15:IDX_BITS+1] == BASE_CMP);
  assign idx_ok  = (32'(idx_reg) < NREGS);
  assign is_ro   = RO_EXT[idx_reg];
  assign tmo_hit = (TMO != 0) && (cnt_reg == TMO_LAST) &&
                   (state_reg == S_SEL || state_reg == S_ACK);
  assign rd_word = is_ro ? rd_stat[idx_reg] : rd_regs[idx_reg];

  always_comb begin
    state_next = state_reg;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    case (state_reg)
      S_IDLE:   if (decode) state_next = S_SEL;
      S_SEL: begin
        // Timeout wins over a strobe arriving in the same cycle: no write.
        if (tmo_hit) begin
          state_next = S_REL;
        end else if (ds_any) begin
          if (!idx_ok) begin
            state_next = S_BERR;
          end else if (!rd_s) begin
            wr_fire    = !is_ro;
            state_next = S_ACK;
          end else begin
            rd_fire    = 1'b1;
            state_next = S_DRIVE;
          end
        end else if (as_s) begin
          state_next = S_IDLE;
        end
      end
      S_DRIVE:  state_next = S_ACK;
      S_ACK:    if (tmo_hit || !ds_any) state_next = S_REL;
      S_BERR:   if (!ds_any) state_next = S_REL;
      S_REL:    state_next = S_WAITAS;
      S_WAITAS: if (as_s) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Bus-facing outputs are registered from the next state so pins never glitch;
  // REL keeps whichever terminator enable was active to drive it high once.
  always_ff @(posedge CLK) begin
    if (CRST) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      rd_reg       <= 1'b0;
      xd_o_reg     <= '0;
      xd_oe_reg    <= 1'b0;
      ddir_reg     <= 1'b0;
      xdtack_reg   <= 1'b1;
      xdtackoe_reg <= 1'b0;
      xberr_reg    <= 1'b1;
      xberroe_reg  <= 1'b0;
      wstb_reg     <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && decode) begin
        idx_reg <= XA[IDX_BITS:1];
        cnt_reg <= '0;
        rd_reg  <= 1'b0;
      end else if (state_reg == S_SEL || state_reg == S_ACK) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (rd_fire) begin
        rd_reg   <= 1'b1;
        xd_o_reg <= rd_word;
      end
      xd_oe_reg    <= (state_next == S_DRIVE) || (state_next == S_ACK && rd_reg);
      ddir_reg     <= (state_next == S_DRIVE) || (state_next == S_ACK && rd_reg);
      xdtack_reg   <= (state_next != S_ACK);
      xdtackoe_reg <= (state_next == S_ACK) || (state_next == S_REL && xdtackoe_reg);
      xberr_reg    <= (state_next != S_BERR);
      xberroe_reg  <= (state_next == S_BERR) || (state_next == S_REL && xberroe_reg);
      wstb_reg     <= wr_fire ? (NREGS'(1) << idx_reg) : '0;
      busy_reg     <= (state_next != S_IDLE);
    end
  end

  // Register file. Indices beyond NREGS exist only as zero read sources so the
  // read mux can be indexed by the full index width.
  genvar gi;
  generate
    for (gi = 0; gi < NIDX; gi++) begin : g_reg
      if (gi < NREGS) begin : g_impl
        logic [DWIDTH-1:0] word_reg;
        always_ff @(posedge CLK) begin
          if (CRST) begin
            word_reg <= '0;
          end else if (wr_fire && idx_reg == IDX_BITS'(gi)) begin
            for (int li = 0; li < LANES; li++) begin
              if (lane_en[li]) word_reg[li*8 +: 8] <= XD_I[li*8 +: 8];
            end
          end
        end
        assign REGS[gi*DWIDTH +: DWIDTH] = word_reg;
        assign rd_regs[gi] = word_reg;
        assign rd_stat[gi] = STAT[gi*DWIDTH +: DWIDTH];
      end else begin : g_none
        assign rd_regs[gi] = '0;
        assign rd_stat[gi] = '0;
      end
    end
  endgenerate

  assign XD_O     = xd_o_reg;
  assign XD_OE    = xd_oe_reg;
  assign DDIR     = ddir_reg;
  assign XDTACK   = xdtack_reg;
  assign XDTACKOE = xdtackoe_reg;
  assign XBERR    = xberr_reg;
  assign XBERROE  = xberroe_reg;
  assign WSTB     = wstb_reg;
  assign BUSY     = busy_reg;

endmodule
